// File: rtl/mem_digital_pkg.sv
// Shared helpers for the digital delay-line family: tap clamping and fill-counter sizing.
package mem_digital_pkg;

   // Bits needed to count 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 32'd1);
   endfunction

   // Map a raw tap select onto a legal tap: 1..depth passes through,
   // 0 and anything above depth fall back to the deepest tap.
   function automatic int unsigned sel_clamp(input int unsigned sel, input int unsigned depth);
      int unsigned eff;
      if ((sel >= 32'd1) && (sel <= depth)) begin
         eff = sel;
      end else begin
         eff = depth;
      end
      return eff;
   endfunction

endpackage

// File: rtl/mem_digital_en.sv
// One stage of the delay line: a width-bit register with enable and flush.
module mem_digital_en
   import mem_digital_pkg::*;
#(
   parameter int unsigned      width = 1,
   parameter logic [width-1:0] init  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cke,
   input  logic             flush,
   input  logic [width-1:0] in,
   output logic [width-1:0] out
);

   logic [width-1:0] data_d;
   logic [width-1:0] data_q;

   // Next stage value: flush wins over enable, otherwise hold.
   always_comb begin
      data_d = data_q;
      if (flush) begin
         data_d = init;
      end else if (cke) begin
         data_d = in;
      end else begin
         data_d = data_q;
      end
   end

   // Stage register with synchronous reset to the init value.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= init;
      end else begin
         data_q <= data_d;
      end
   end

   assign out = data_q;

endmodule

// File: rtl/mem_digital_delay.sv
// Programmable integer-cycle delay line with fill tracking and a selectable tap.
module mem_digital_delay
   import mem_digital_pkg::*;
#(
   parameter int unsigned      width     = 1,
   parameter logic [width-1:0] init      = '0,
   parameter int unsigned      depth     = 4,
   parameter int unsigned      sel_width = $clog2(depth + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cke,
   input  logic                 flush,
   input  logic [width-1:0]     in,
   input  logic [sel_width-1:0] sel,
   output logic [width-1:0]     out,
   output logic                 primed
);

   localparam int unsigned      cnt_w   = cnt_width(depth);
   localparam logic [cnt_w-1:0] cnt_max = cnt_w'(depth);
   localparam logic [cnt_w-1:0] cnt_one = cnt_w'(1);

   logic [width-1:0] stage_s [depth];
   logic [cnt_w-1:0] cnt_d;
   logic [cnt_w-1:0] cnt_q;
   int unsigned      eff_s;
   logic [width-1:0] out_s;
   logic             primed_s;

   // Register chain: stage 0 takes the input, each later stage takes its predecessor.
   for (genvar k = 0; k < depth; k++) begin : g_stage
      if (k == 0) begin : g_first
         mem_digital_en #(.width(width), .init(init)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .cke  (cke),
            .flush(flush),
            .in   (in),
            .out  (stage_s[k])
         );
      end else begin : g_rest
         mem_digital_en #(.width(width), .init(init)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .cke  (cke),
            .flush(flush),
            .in   (stage_s[k-1]),
            .out  (stage_s[k])
         );
      end
   end

   // Fill count: cleared by flush, bumped on each accepted sample, saturates at depth.
   always_comb begin
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = {cnt_w{1'b0}};
      end else if (cke && (cnt_q != cnt_max)) begin
         cnt_d = cnt_q + cnt_one;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Fill count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {cnt_w{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Tap mux and primed flag; combinational so a sel change is seen in the same cycle.
   always_comb begin
      eff_s = sel_clamp(32'(sel), depth);
      out_s = stage_s[depth-1];
      for (int k = 0; k < depth; k++) begin
         out_s = (eff_s == 32'(k + 1)) ? stage_s[k] : out_s;
      end
      primed_s = (32'(cnt_q) >= eff_s);
   end

   assign out    = out_s;
   assign primed = primed_s;

endmodule

// File: tb/tb_mem_digital_delay.sv
// Scoreboard bench for mem_digital_delay: depth-4 and depth-1 instances share stimulus.
module tb_mem_digital_delay;

   typedef struct {
      int         tid;
      bit         k4;
      logic [7:0] eo;
      logic       ep;
      bit         k1;
      logic [7:0] eo1;
      logic       ep1;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cke = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] din = 8'h00;
   logic [2:0] sel4 = 3'd3;
   logic [0:0] sel1 = 1'b0;
   logic [7:0] out4;
   logic       pr4;
   logic [7:0] out1;
   logic       pr1;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   mem_digital_delay #(.width(8), .init(8'hA5), .depth(4)) dut4 (
      .clk(clk), .rst(rst), .cke(cke), .flush(flush),
      .in(din), .sel(sel4), .out(out4), .primed(pr4)
   );

   mem_digital_delay #(.width(8), .init(8'hA5), .depth(1)) dut1 (
      .clk(clk), .rst(rst), .cke(cke), .flush(flush),
      .in(din), .sel(sel1), .out(out1), .primed(pr1)
   );

   // Monitor: pop one expectation per cycle and compare away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.k4) begin
            vectors++;
            if ((out4 !== e.eo) || (pr4 !== e.ep)) begin
               miscompares++;
               $display("FAIL t%0d depth4: out=%h primed=%b, expected out=%h primed=%b",
                        e.tid, out4, pr4, e.eo, e.ep);
            end
         end
         if (e.k1) begin
            vectors++;
            if ((out1 !== e.eo1) || (pr1 !== e.ep1)) begin
               miscompares++;
               $display("FAIL t%0d depth1: out=%h primed=%b, expected out=%h primed=%b",
                        e.tid, out1, pr1, e.eo1, e.ep1);
            end
         end
      end
   end

   // Apply one cycle of inputs, then queue what both instances should show after the edge.
   task automatic step(input logic r, input logic c, input logic f, input logic [7:0] d,
                       input logic [2:0] s, input bit k4, input logic [7:0] eo, input logic ep,
                       input bit k1, input logic [7:0] eo1, input logic ep1, input int tid);
      exp_t e;
      rst = r; cke = c; flush = f; din = d; sel4 = s;
      @(posedge clk);
      #1;
      if (k4 || k1) begin
         e.tid = tid; e.k4 = k4; e.eo = eo; e.ep = ep;
         e.k1 = k1; e.eo1 = eo1; e.ep1 = ep1;
         sb.push_back(e);
      end
      @(negedge clk);
      #1;
   endtask

   // Depth-4 only check.
   task automatic s4(input logic c, input logic f, input logic [7:0] d, input logic [2:0] s,
                     input logic [7:0] eo, input logic ep, input int tid);
      step(1'b0, c, f, d, s, 1'b1, eo, ep, 1'b0, 8'h00, 1'b0, tid);
   endtask

   initial begin
      // 1: reset then sel=3 tap; depth-1 instance tracks input with one cycle delay
      step(1'b1, 1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1);
      step(1'b1, 1'b1, 1'b0, 8'h77, 3'd3, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1);
      step(1'b0, 1'b1, 1'b0, 8'h01, 3'd3, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h01, 1'b1, 1);
      step(1'b0, 1'b1, 1'b0, 8'h02, 3'd3, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h02, 1'b1, 1);
      step(1'b0, 1'b1, 1'b0, 8'h03, 3'd3, 1'b1, 8'h01, 1'b1, 1'b1, 8'h03, 1'b1, 1);
      step(1'b0, 1'b1, 1'b0, 8'h04, 3'd3, 1'b1, 8'h02, 1'b1, 1'b1, 8'h04, 1'b1, 1);
      step(1'b0, 1'b1, 1'b0, 8'h05, 3'd3, 1'b1, 8'h03, 1'b1, 1'b1, 8'h05, 1'b1, 1);

      // 2: sel=0 and sel=7 both clamp to the deepest tap
      for (int v = 0; v < 2; v++) begin
         logic [2:0] sv;
         sv = (v == 0) ? 3'd0 : 3'd7;
         s4(1'b1, 1'b1, 8'h33, sv, 8'hA5, 1'b0, 2);
         s4(1'b1, 1'b0, 8'h01, sv, 8'hA5, 1'b0, 2);
         s4(1'b1, 1'b0, 8'h02, sv, 8'hA5, 1'b0, 2);
         s4(1'b1, 1'b0, 8'h03, sv, 8'hA5, 1'b0, 2);
         s4(1'b1, 1'b0, 8'h04, sv, 8'h01, 1'b1, 2);
         s4(1'b1, 1'b0, 8'h05, sv, 8'h02, 1'b1, 2);
      end

      // 3: enable gating drops 11
      s4(1'b1, 1'b1, 8'h33, 3'd1, 8'hA5, 1'b0, 3);
      s4(1'b1, 1'b0, 8'h0A, 3'd1, 8'h0A, 1'b1, 3);
      s4(1'b0, 1'b0, 8'h0B, 3'd1, 8'h0A, 1'b1, 3);
      s4(1'b1, 1'b0, 8'h0C, 3'd1, 8'h0C, 1'b1, 3);
      s4(1'b0, 1'b0, 8'h0B, 3'd2, 8'h0A, 1'b1, 3);

      // 4: fill to cnt=4, then flush with cke high; 8'h33 must not land anywhere
      s4(1'b1, 1'b0, 8'h14, 3'd4, 8'hA5, 1'b0, 4);
      s4(1'b1, 1'b0, 8'h15, 3'd4, 8'h0A, 1'b1, 4);
      s4(1'b1, 1'b1, 8'h33, 3'd4, 8'hA5, 1'b0, 4);
      s4(1'b0, 1'b0, 8'h00, 3'd1, 8'hA5, 1'b0, 4);
      s4(1'b0, 1'b0, 8'h00, 3'd2, 8'hA5, 1'b0, 4);
      s4(1'b0, 1'b0, 8'h00, 3'd3, 8'hA5, 1'b0, 4);

      // 5: refill with 3,4 (cnt=2), then move the tap with the chain frozen
      s4(1'b1, 1'b0, 8'h03, 3'd1, 8'h03, 1'b1, 5);
      s4(1'b1, 1'b0, 8'h04, 3'd1, 8'h04, 1'b1, 5);
      s4(1'b0, 1'b0, 8'h99, 3'd4, 8'hA5, 1'b0, 5);
      s4(1'b0, 1'b0, 8'h99, 3'd1, 8'h04, 1'b1, 5);
      s4(1'b0, 1'b0, 8'h99, 3'd2, 8'h03, 1'b1, 5);
      s4(1'b0, 1'b0, 8'h99, 3'd3, 8'hA5, 1'b0, 5);

      // 6: long run for saturation on depth 4 and single-stage behaviour on depth 1
      step(1'b0, 1'b1, 1'b1, 8'h33, 3'd4, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 6);
      for (int j = 1; j <= 1000; j++) begin
         step(1'b0, 1'b1, 1'b0, 8'(j), 3'd4,
              1'b1, (j >= 4) ? 8'(j - 3) : 8'hA5, (j >= 4) ? 1'b1 : 1'b0,
              1'b1, 8'(j), 1'b1, 6);
      end

      // Drain the scoreboard with a bounded wait.
      for (int w = 0; w < 5 && sb.size() > 0; w++) begin
         @(negedge clk);
      end
      if (sb.size() > 0) begin
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
         miscompares += sb.size();
      end
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
